// File: rtl/bcd_seg7_counter.sv
// bcd_seg7_counter: multi-digit BCD up/down counter with prescaler and
// a time-multiplexed common-cathode seven-segment scan driver.
// Optional build macro: SEG7_LEADING_BLANK_EN (leading-zero blanking).
module bcd_seg7_counter #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned MUX_DIV  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  up,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int unsigned CW = 4 * DIGITS;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned SW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam int unsigned KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] S_LAST = SW'(MUX_DIV - 1);
    localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

    logic [PW-1:0] p;
    logic [SW-1:0] s;
    logic [KW-1:0] k;

    logic          step_c;
    logic [CW-1:0] cnt_next_c;
    logic          carry_c;
    logic [3:0]    cur_digit_c;
    logic          blank_c;
    logic [DIGITS-1:0] dig_next_c;

    // Seven-segment decode {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    // A step cycle is the last prescaler cycle while running.
    assign step_c = run && (p == P_LAST);

    // Prescaler: frozen while run is low, cleared by clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else if (clr) begin
            p <= '0;
        end else if (run) begin
            if (step_c) begin
                p <= '0;
            end else begin
                p <= p + PW'(1);
            end
        end
    end

    // Ripple-carry BCD increment / ripple-borrow decrement; carry out of the top digit is the wrap.
    always_comb begin
        logic [3:0] d;
        logic       c;
        cnt_next_c = count_bcd;
        c          = 1'b1;
        d          = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = count_bcd[4*i +: 4];
            if (c) begin
                if (up) begin
                    if (d >= 4'd9) begin
                        cnt_next_c[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_next_c[4*i +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        cnt_next_c[4*i +: 4] = 4'd9;
                    end else begin
                        cnt_next_c[4*i +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        carry_c = c;
    end

    // Count register and one-cycle wrap pulse; clear wins over a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_bcd <= '0;
            wrap      <= 1'b0;
        end else if (clr) begin
            count_bcd <= '0;
            wrap      <= 1'b0;
        end else if (step_c) begin
            count_bcd <= cnt_next_c;
            wrap      <= carry_c;
        end else begin
            wrap      <= 1'b0;
        end
    end

    // Free-running scan divider and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= '0;
            k <= '0;
        end else if (s == S_LAST) begin
            s <= '0;
            if (k == K_LAST) begin
                k <= '0;
            end else begin
                k <= k + KW'(1);
            end
        end else begin
            s <= s + SW'(1);
        end
    end

    // Select the scanned digit value and its one-hot enable.
    always_comb begin
        cur_digit_c = 4'd0;
        dig_next_c  = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (KW'(i) == k) begin
                cur_digit_c   = count_bcd[4*i +: 4];
                dig_next_c[i] = 1'b1;
            end
        end
    end

`ifdef SEG7_LEADING_BLANK_EN
    // Blank digit k (k>=1) when it and every higher digit are zero.
    always_comb begin
        logic zero_hi;
        zero_hi = 1'b1;
        blank_c = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_hi = zero_hi && (count_bcd[4*i +: 4] == 4'd0);
            if ((KW'(i) == k) && (i != 0)) begin
                blank_c = zero_hi;
            end
        end
    end
`else
    // Every digit is shown, zeros included.
    assign blank_c = 1'b0;
`endif

    // Display register: segments and digit enable always move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg     <= 7'h00;
            dig_sel <= '0;
        end else begin
            seg     <= blank_c ? 7'h00 : seg_decode(cur_digit_c);
            dig_sel <= dig_next_c;
        end
    end

endmodule
